// File: rtl/gb_ppu_pkg.sv
// Shared definitions for the PPU-side blocks: DMA state encoding, the
// register/memory map constants used by OAM DMA, and the echo-RAM source
// page folding helper.
package gb_ppu_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        XFER = 1'b1
    } DMA_STATES_t;

    localparam logic [15:0] DMA_REG_ADDR   = 16'hFF46;
    localparam logic [15:0] OAM_BASE_ADDR  = 16'hFE00;
    localparam logic [7:0]  ECHO_MIRROR_HI = 8'hE0;

    // Pages E0..FF alias work RAM at C0..DF, so the DMA reads the mirrored page.
    function automatic logic [7:0] dma_src_page(input logic [7:0] reg_val);
        return (reg_val >= ECHO_MIRROR_HI) ? (reg_val - 8'h20) : reg_val;
    endfunction

endpackage

// File: rtl/oam_dma_ctrl_if.sv
// Bus bundle for the OAM DMA sequencer: CPU MMIO access to FF46, the
// source-read port toward the system memory mux and the OAM write port.
// The slave modport is the DMA controller's view; master is the system side.
interface oam_dma_ctrl_if;

    // CPU MMIO side
    logic [15:0] ADDR;
    logic        WR;
    logic        RD;
    logic [7:0]  MMIO_DATA_out;
    logic [7:0]  MMIO_DATA_in;

    // Bus-lock flag toward the arbiter
    logic        DMA_ACTIVE;

    // Source read port (1-cycle synchronous memory behind the mux)
    logic        DMA_RD;
    logic [15:0] DMA_SRC_ADDR;
    logic [7:0]  DMA_SRC_DATA;

    // OAM write port
    logic        OAM_WR;
    logic [7:0]  OAM_ADDR;
    logic [7:0]  OAM_DATA;

    modport slave (
        input  ADDR,
        input  WR,
        input  RD,
        input  MMIO_DATA_out,
        output MMIO_DATA_in,
        output DMA_ACTIVE,
        output DMA_RD,
        output DMA_SRC_ADDR,
        input  DMA_SRC_DATA,
        output OAM_WR,
        output OAM_ADDR,
        output OAM_DATA
    );

    modport master (
        output ADDR,
        output WR,
        output RD,
        output MMIO_DATA_out,
        input  MMIO_DATA_in,
        input  DMA_ACTIVE,
        input  DMA_RD,
        input  DMA_SRC_ADDR,
        output DMA_SRC_DATA,
        input  OAM_WR,
        input  OAM_ADDR,
        input  OAM_DATA
    );

endinterface

// File: rtl/oam_dma_ctrl.sv
// OAM DMA sequencer. A CPU write to FF46 copies OAM_LEN bytes from page
// {FF46, 8'h00} into OAM, one byte every BYTE_CYCLES clocks:
//   phase 0           : issue source read at {src_hi, idx}
//   phase 1           : capture returned source byte
//   phase BYTE_CYCLES-1: write captured byte to OAM[idx]
// A new FF46 write at any time restarts the copy from byte 0; it wins over
// the completion of the final byte. DMA_ACTIVE doubles as the bus-lock flag.
module oam_dma_ctrl
    import gb_ppu_pkg::*;
#(
    parameter int BYTE_CYCLES = 4,
    parameter int OAM_LEN     = 160
) (
    input logic           clk,
    input logic           rst,
    oam_dma_ctrl_if.slave bus
);

    localparam logic [3:0] LAST_PHASE = 4'(BYTE_CYCLES - 1);
    localparam logic [7:0] LAST_IDX   = 8'(OAM_LEN - 1);

    DMA_STATES_t state_q, state_d;
    logic [7:0]  ff46_q, ff46_d;
    logic [7:0]  src_hi_q, src_hi_d;
    logic [7:0]  idx_q, idx_d;
    logic [3:0]  phase_q, phase_d;
    logic [7:0]  buf_q, buf_d;
    logic [15:0] src_addr_q, src_addr_d;
    logic [7:0]  oam_addr_q, oam_addr_d;
    logic [7:0]  oam_data_q, oam_data_d;

    logic        trigger;
    logic        rd_pulse;
    logic        wr_pulse;

    // Decode the FF46 write and the per-byte strobe phases.
    always_comb begin
        trigger  = bus.WR && (bus.ADDR == DMA_REG_ADDR);
        rd_pulse = (state_q == XFER) && (phase_q == 4'd0);
        wr_pulse = (state_q == XFER) && (phase_q == LAST_PHASE);
    end

    // Next-state logic: byte sequencing, buffering and FF46 restart.
    always_comb begin
        state_d    = state_q;
        ff46_d     = ff46_q;
        src_hi_d   = src_hi_q;
        idx_d      = idx_q;
        phase_d    = phase_q;
        buf_d      = buf_q;
        src_addr_d = src_addr_q;
        oam_addr_d = oam_addr_q;
        oam_data_d = oam_data_q;

        case (state_q)
            IDLE: begin
                phase_d = 4'd0;
            end
            XFER: begin
                if (phase_q == 4'd1) begin
                    buf_d = bus.DMA_SRC_DATA;
                end
                if (phase_q == LAST_PHASE) begin
                    phase_d = 4'd0;
                    if (idx_q == LAST_IDX) begin
                        state_d = IDLE;
                        idx_d   = 8'd0;
                    end else begin
                        idx_d = idx_q + 8'd1;
                    end
                end else begin
                    phase_d = phase_q + 4'd1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Remember the last presented addresses/data so the ports hold between strobes.
        if (rd_pulse) begin
            src_addr_d = {src_hi_q, idx_q};
        end
        if (wr_pulse) begin
            oam_addr_d = idx_q;
            oam_data_d = buf_q;
        end

        // A register write always (re)starts the copy, even on the last byte.
        if (trigger) begin
            ff46_d   = bus.MMIO_DATA_out;
            src_hi_d = dma_src_page(bus.MMIO_DATA_out);
            idx_d    = 8'd0;
            phase_d  = 4'd0;
            state_d  = XFER;
        end
    end

    // State and datapath registers; reset drops the transfer immediately.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            ff46_q     <= 8'h00;
            src_hi_q   <= 8'h00;
            idx_q      <= 8'd0;
            phase_q    <= 4'd0;
            buf_q      <= 8'h00;
            src_addr_q <= 16'h0000;
            oam_addr_q <= 8'h00;
            oam_data_q <= 8'h00;
        end else begin
            state_q    <= state_d;
            ff46_q     <= ff46_d;
            src_hi_q   <= src_hi_d;
            idx_q      <= idx_d;
            phase_q    <= phase_d;
            buf_q      <= buf_d;
            src_addr_q <= src_addr_d;
            oam_addr_q <= oam_addr_d;
            oam_data_q <= oam_data_d;
        end
    end

    // Output drive: strobes come straight from state/phase so reset kills them at once.
    always_comb begin
        bus.MMIO_DATA_in = (bus.ADDR == DMA_REG_ADDR) ? ff46_q : 8'hFF;
        bus.DMA_ACTIVE   = (state_q == XFER);
        bus.DMA_RD       = rd_pulse;
        bus.DMA_SRC_ADDR = rd_pulse ? {src_hi_q, idx_q} : src_addr_q;
        bus.OAM_WR       = wr_pulse;
        bus.OAM_ADDR     = wr_pulse ? idx_q : oam_addr_q;
        bus.OAM_DATA     = wr_pulse ? buf_q : oam_data_q;
    end

endmodule

// File: tb/tb_oam_dma_ctrl.sv
// Bench for oam_dma_ctrl: two instances (BYTE_CYCLES 4 and 3) driven with
// randomized MMIO traffic, compared every cycle against a transfer-level
// reference model (cycles since trigger -> byte number and phase).
module tb_oam_dma_ctrl;

    localparam int LEN = 160;

    logic clk = 1'b0;
    logic rst_n;

    always #5 clk = ~clk;

    oam_dma_ctrl_if if0 ();
    oam_dma_ctrl_if if1 ();

    oam_dma_ctrl #(.BYTE_CYCLES(4), .OAM_LEN(LEN)) dut0 (
        .clk (clk),
        .rst (rst_n),
        .bus (if0.slave)
    );

    oam_dma_ctrl #(.BYTE_CYCLES(3), .OAM_LEN(LEN)) dut1 (
        .clk (clk),
        .rst (rst_n),
        .bus (if1.slave)
    );

    // Stimulus and observation arrays, indexed by instance
    logic [15:0] addr_v [2];
    logic        wr_v   [2];
    logic        rd_v   [2];
    logic [7:0]  wdat_v [2];
    logic [7:0]  sdata  [2];

    logic [7:0]  mmio_o  [2];
    logic        act_o   [2];
    logic        rd_o    [2];
    logic        wr_o    [2];
    logic [15:0] saddr_o [2];
    logic [7:0]  oaddr_o [2];
    logic [7:0]  odata_o [2];

    assign if0.ADDR          = addr_v[0];
    assign if0.WR            = wr_v[0];
    assign if0.RD            = rd_v[0];
    assign if0.MMIO_DATA_out = wdat_v[0];
    assign if0.DMA_SRC_DATA  = sdata[0];
    assign if1.ADDR          = addr_v[1];
    assign if1.WR            = wr_v[1];
    assign if1.RD            = rd_v[1];
    assign if1.MMIO_DATA_out = wdat_v[1];
    assign if1.DMA_SRC_DATA  = sdata[1];

    assign mmio_o[0]  = if0.MMIO_DATA_in;
    assign act_o[0]   = if0.DMA_ACTIVE;
    assign rd_o[0]    = if0.DMA_RD;
    assign wr_o[0]    = if0.OAM_WR;
    assign saddr_o[0] = if0.DMA_SRC_ADDR;
    assign oaddr_o[0] = if0.OAM_ADDR;
    assign odata_o[0] = if0.OAM_DATA;
    assign mmio_o[1]  = if1.MMIO_DATA_in;
    assign act_o[1]   = if1.DMA_ACTIVE;
    assign rd_o[1]    = if1.DMA_RD;
    assign wr_o[1]    = if1.OAM_WR;
    assign saddr_o[1] = if1.DMA_SRC_ADDR;
    assign oaddr_o[1] = if1.OAM_ADDR;
    assign odata_o[1] = if1.OAM_DATA;

    // Source memory content: depends on both address bytes so a wrong page shows in the data.
    function automatic logic [7:0] mem_byte(input logic [15:0] a);
        return a[7:0] ^ a[15:8];
    endfunction

    // 1-cycle synchronous source memory
    always @(posedge clk) begin
        if (rd_o[0]) sdata[0] <= mem_byte(saddr_o[0]);
        if (rd_o[1]) sdata[1] <= mem_byte(saddr_o[1]);
    end

    // Reference model state
    int         bc    [2];
    int         k     [2];   // cycles elapsed since the transfer started
    bit         act   [2];
    logic [7:0] src   [2];
    logic [7:0] ff46m [2];
    logic [15:0] lsrc [2];
    logic [7:0] loa   [2];
    logic [7:0] lod   [2];

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            act[d]   = 1'b0;
            k[d]     = 0;
            src[d]   = 8'h00;
            ff46m[d] = 8'h00;
            lsrc[d]  = 16'h0000;
            loa[d]   = 8'h00;
            lod[d]   = 8'h00;
        end
    endtask

    // One clock: inputs sampled at posedge, model advanced and outputs compared at negedge.
    task automatic tick();
        bit         pend [2];
        logic [7:0] pd   [2];
        bit         e_rd, e_wr;
        int         bi;
        logic [7:0] b8;
        logic [7:0] e_mmio;
        for (int d = 0; d < 2; d++) begin
            pend[d] = rst_n && wr_v[d] && (addr_v[d] == 16'hFF46);
            pd[d]   = wdat_v[d];
        end
        @(posedge clk);
        for (int d = 0; d < 2; d++) begin
            if (pend[d]) ff46m[d] = pd[d];
        end
        @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            if (!rst_n) begin
                act[d] = 1'b0; k[d] = 0; ff46m[d] = 8'h00;
                lsrc[d] = 16'h0000; loa[d] = 8'h00; lod[d] = 8'h00;
            end else if (pend[d]) begin
                act[d] = 1'b1;
                k[d]   = 0;
                src[d] = (pd[d] >= 8'd224) ? pd[d] - 8'd32 : pd[d];
            end else if (act[d]) begin
                k[d]++;
                if (k[d] >= LEN * bc[d]) act[d] = 1'b0;
            end
            e_rd = act[d] && (k[d] % bc[d] == 0);
            e_wr = act[d] && (k[d] % bc[d] == bc[d] - 1);
            bi   = k[d] / bc[d];
            b8   = bi[7:0];
            if (e_rd) lsrc[d] = {src[d], b8};
            if (e_wr) begin
                loa[d] = b8;
                lod[d] = mem_byte({src[d], b8});
            end
            e_mmio = (addr_v[d] == 16'hFF46) ? ff46m[d] : 8'hFF;
            chk($sformatf("d%0d active", d), act_o[d], act[d]);
            chk($sformatf("d%0d dma_rd", d), rd_o[d], e_rd);
            chk($sformatf("d%0d oam_wr", d), wr_o[d], e_wr);
            chk($sformatf("d%0d overlap", d), rd_o[d] & wr_o[d], 1'b0);
            chk($sformatf("d%0d src_addr", d), saddr_o[d], lsrc[d]);
            chk($sformatf("d%0d oam_addr", d), oaddr_o[d], loa[d]);
            chk($sformatf("d%0d oam_data", d), odata_o[d], lod[d]);
            chk($sformatf("d%0d mmio_rd", d), mmio_o[d], e_mmio);
        end
    endtask

    task automatic wr_reg(input int d, input logic [15:0] a, input logic [7:0] v);
        addr_v[d] = a;
        wdat_v[d] = v;
        wr_v[d]   = 1'b1;
        tick();
        wr_v[d]   = 1'b0;
    endtask

    task automatic wr_other(input int d);
        logic [15:0] a;
        a = 16'($urandom);
        if (a == 16'hFF46) a = 16'hFF47;
        wr_reg(d, a, 8'($urandom));
    endtask

    task automatic idle_run(input int n);
        for (int i = 0; i < n; i++) begin
            for (int d = 0; d < 2; d++) begin
                case ($urandom_range(0, 2))
                    0:       addr_v[d] = 16'hFF46;
                    1:       addr_v[d] = 16'hFF40;
                    default: addr_v[d] = 16'($urandom);
                endcase
                rd_v[d] = 1'($urandom);
            end
            tick();
        end
    endtask

    task automatic wait_k(input int d, input int target);
        int n;
        n = 0;
        while (!(act[d] && k[d] == target) && n < 4000) begin
            tick();
            n++;
        end
        chk($sformatf("d%0d reach k=%0d", d, target), (act[d] && k[d] == target), 1'b1);
    endtask

    task automatic measure(input int d, output int n_act, output int n_wr,
                           output logic [15:0] first_rd, output logic [15:0] last_rd);
        bit got;
        got = 1'b0;
        n_act = 0; n_wr = 0; first_rd = 16'h0000; last_rd = 16'h0000;
        while (act_o[d] && n_act < 5000) begin
            if (rd_o[d]) begin
                if (!got) first_rd = saddr_o[d];
                got = 1'b1;
                last_rd = saddr_o[d];
            end
            if (wr_o[d]) n_wr++;
            n_act++;
            tick();
        end
        chk($sformatf("d%0d transfer ends", d), act_o[d], 1'b0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int          na, nw, nwr;
        logic [15:0] f, l;
        logic [7:0]  v;

        bc[0] = 4;
        bc[1] = 3;
        for (int d = 0; d < 2; d++) begin
            addr_v[d] = 16'h0000; wr_v[d] = 1'b0; rd_v[d] = 1'b0; wdat_v[d] = 8'h00;
        end
        model_reset();
        rst_n = 1'b0;
        repeat (3) tick();
        rst_n = 1'b1;

        // Register readback after reset
        addr_v[0] = 16'hFF46; rd_v[0] = 1'b1;
        tick();
        chk("reset ff46 readback", mmio_o[0], 8'h00);
        addr_v[0] = 16'hFF40;
        tick();
        chk("ff40 readback", mmio_o[0], 8'hFF);
        idle_run(10);

        // Plain transfer from C1xx
        wr_reg(0, 16'hFF46, 8'hC1);
        measure(0, na, nw, f, l);
        chk("C1 active cycles", na, 640);
        chk("C1 oam_wr count", nw, 160);
        chk("C1 first src", f, 16'hC100);
        chk("C1 last src", l, 16'hC19F);
        idle_run(5);

        // Echo-RAM page folds to C3
        wr_reg(0, 16'hFF46, 8'hE3);
        chk("E3 first src", saddr_o[0], 16'hC300);
        chk("E3 readback", mmio_o[0], 8'hE3);
        measure(0, na, nw, f, l);
        chk("E3 last src", l, 16'hC39F);
        idle_run(5);

        // Restart at byte 50 phase 2
        wr_reg(0, 16'hFF46, 8'hC0);
        wait_k(0, 50 * 4 + 2);
        wr_reg(0, 16'hFF46, 8'hD0);
        chk("restart src", saddr_o[0], 16'hD000);
        chk("restart no wr", wr_o[0], 1'b0);
        measure(0, na, nw, f, l);
        chk("restart active cycles", na, 640);
        chk("restart oam_wr count", nw, 160);
        idle_run(5);

        // Restart coincident with the final byte write
        wr_reg(0, 16'hFF46, 8'($urandom));
        wait_k(0, LEN * 4 - 1);
        chk("final wr present", wr_o[0], 1'b1);
        chk("final wr addr", oaddr_o[0], 8'd159);
        v = 8'($urandom);
        wr_reg(0, 16'hFF46, v);
        chk("coincident stays active", act_o[0], 1'b1);
        measure(0, na, nw, f, l);
        chk("coincident active cycles", na, 640);
        chk("coincident oam_wr count", nw, 160);

        // Random sources, stray writes to other addresses mid-transfer
        for (int r = 0; r < 3; r++) begin
            idle_run($urandom_range(1, 8));
            wr_reg(0, 16'hFF46, 8'($urandom));
            wait_k(0, $urandom_range(0, 600));
            wr_other(0);
            measure(0, na, nw, f, l);
        end

        // Asynchronous reset at byte 80
        wr_reg(0, 16'hFF46, 8'($urandom));
        wait_k(0, 80 * 4);
        chk("rd before reset", rd_o[0], 1'b1);
        #1 rst_n = 1'b0;
        #1;
        chk("async rst dma_rd", rd_o[0], 1'b0);
        chk("async rst active", act_o[0], 1'b0);
        chk("async rst oam_wr", wr_o[0], 1'b0);
        chk("async rst src_addr", saddr_o[0], 16'h0000);
        model_reset();
        repeat (2) tick();
        rst_n = 1'b1;
        nwr = 0;
        for (int i = 0; i < 700; i++) begin
            tick();
            if (wr_o[0] || act_o[0]) nwr++;
        end
        chk("no activity after reset", nwr, 0);

        // BYTE_CYCLES = 3 instance
        wr_reg(1, 16'hFF46, 8'($urandom));
        measure(1, na, nw, f, l);
        chk("bc3 active cycles", na, 480);
        chk("bc3 oam_wr count", nw, 160);
        idle_run(4);
        wr_reg(1, 16'hFF46, 8'($urandom));
        wait_k(1, $urandom_range(1, 470));
        wr_reg(1, 16'hFF46, 8'($urandom));
        measure(1, na, nw, f, l);
        chk("bc3 restart active cycles", na, 480);
        chk("bc3 restart oam_wr count", nw, 160);
        idle_run(5);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
